// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU result stream with buffered, extended load responses
// onto the single integer register-file write port.
module wb_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_alu_valid,
  input  logic [4:0]               i_alu_rd,
  input  logic [31:0]              i_alu_data,
  output logic                     o_alu_stall,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [4:0]               i_ld_rd,
  input  logic [2:0]               i_ld_funct3,
  input  logic [1:0]               i_ld_offset,
  input  logic [31:0]              i_ld_word,
  output logic [$clog2(DEPTH):0]   o_ld_count,
  output logic [31:0]              o_write_data,
  output logic [4:0]               o_write_address,
  output logic                     o_reg_write_en
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FullCnt   = CW'(DEPTH);
  localparam logic [SW-1:0] StarveLim = SW'(STARVE_MAX);

  logic [31:0]   r_fifo_data [DEPTH];
  logic [4:0]    r_fifo_rd   [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_alu_stall;
  logic [31:0]   r_write_data;
  logic [4:0]    r_write_address;
  logic          r_reg_write_en;

  logic          w_full;
  logic          w_empty;
  logic          w_ld_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_alu_sel;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext_data;
  logic [CW-1:0] w_count_nxt;
  logic [SW-1:0] w_starve_nxt;
  logic          w_stall_nxt;
  logic          w_we_nxt;
  logic [4:0]    w_wa_nxt;
  logic [31:0]   w_wd_nxt;

  assign w_full     = (r_count == FullCnt);
  assign w_empty    = (r_count == '0);
  // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
  assign w_ld_ready = !w_full && !i_rst;
  // x0 loads complete the handshake but are never stored.
  assign w_push     = i_ld_valid && w_ld_ready && (i_ld_rd != 5'd0);
  assign w_alu_sel  = !r_alu_stall && i_alu_valid && (i_alu_rd != 5'd0);
  assign w_pop      = !w_alu_sel && !w_empty;

  always_comb begin
    w_byte = 8'h00;
    unique case (i_ld_offset)
      2'd0: w_byte = i_ld_word[7:0];
      2'd1: w_byte = i_ld_word[15:8];
      2'd2: w_byte = i_ld_word[23:16];
      2'd3: w_byte = i_ld_word[31:24];
    endcase
    w_half = i_ld_offset[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    case (i_ld_funct3)
      3'b000:  w_ext_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext_data = {24'h000000, w_byte};
      3'b101:  w_ext_data = {16'h0000, w_half};
      default: w_ext_data = i_ld_word;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Starvation guard: count edges where buffered loads are blocked by the ALU.
  always_comb begin
    w_starve_nxt = r_starve;
    w_stall_nxt  = r_alu_stall;
    if (w_empty) begin
      w_starve_nxt = '0;
      w_stall_nxt  = 1'b0;
    end else if (w_pop) begin
      w_starve_nxt = '0;
    end else if (r_starve != StarveLim) begin
      w_starve_nxt = r_starve + 1'b1;
    end
    if (!w_empty && (w_starve_nxt == StarveLim)) begin
      w_stall_nxt = 1'b1;
    end
  end

  always_comb begin
    w_we_nxt = 1'b0;
    w_wa_nxt = r_write_address;
    w_wd_nxt = r_write_data;
    if (w_alu_sel) begin
      w_we_nxt = 1'b1;
      w_wa_nxt = i_alu_rd;
      w_wd_nxt = i_alu_data;
    end else if (w_pop) begin
      w_we_nxt = 1'b1;
      w_wa_nxt = r_fifo_rd[r_rptr];
      w_wd_nxt = r_fifo_data[r_rptr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= w_ext_data;
      r_fifo_rd[r_wptr]   <= i_ld_rd;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_starve        <= '0;
      r_alu_stall     <= 1'b0;
      r_write_data    <= 32'h0;
      r_write_address <= 5'd0;
      r_reg_write_en  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count         <= w_count_nxt;
      r_starve        <= w_starve_nxt;
      r_alu_stall     <= w_stall_nxt;
      r_write_data    <= w_wd_nxt;
      r_write_address <= w_wa_nxt;
      r_reg_write_en  <= w_we_nxt;
    end
  end

  assign o_alu_stall     = r_alu_stall;
  assign o_ld_ready      = w_ld_ready;
  assign o_ld_count      = r_count;
  assign o_write_data    = r_write_data;
  assign o_write_address = r_write_address;
  assign o_reg_write_en  = r_reg_write_en;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts every write-port
// cycle; a separate monitor compares the DUT after each clock edge.
module tb_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [31:0] ld_word;
  logic [2:0]  ld_count;
  logic [31:0] wd;
  logic [4:0]  wa;
  logic        we;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .o_alu_stall(alu_stall),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_rd(ld_rd),
    .i_ld_funct3(ld_funct3), .i_ld_offset(ld_offset), .i_ld_word(ld_word),
    .o_ld_count(ld_count),
    .o_write_data(wd), .o_write_address(wa), .o_reg_write_en(we)
  );

  typedef struct {
    bit        en;
    bit [4:0]  addr;
    bit [31:0] data;
    bit        stall;
    int        count;
  } exp_t;

  typedef struct {
    bit [4:0]  rd;
    bit [31:0] data;
  } ld_t;

  exp_t      exp_q[$];
  ld_t       m_fifo[$];
  bit        m_stall;
  int        m_starve;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  int        checks = 0;
  int        errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Load extension from the funct3 table using plain arithmetic.
  function automatic bit [31:0] ext_ref(input bit [2:0] f3, input bit [1:0] off,
                                        input bit [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * off[1])) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_stall  = 1'b0;
    m_starve = 0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  // Predict the effect of the coming edge from the current inputs.
  task automatic model_edge();
    exp_t e;
    ld_t  h;
    ld_t  n;
    int   pre;
    bit   popped;
    pre    = m_fifo.size();
    popped = 1'b0;
    e.en   = 1'b0;
    if (!m_stall && alu_valid && alu_rd != 0) begin
      e.en   = 1'b1;
      m_addr = alu_rd;
      m_data = alu_data;
    end else if (pre > 0) begin
      h      = m_fifo.pop_front();
      e.en   = 1'b1;
      m_addr = h.rd;
      m_data = h.data;
      popped = 1'b1;
    end
    if (ld_valid && pre < DEPTH && ld_rd != 0) begin
      n.rd   = ld_rd;
      n.data = ext_ref(ld_funct3, ld_offset, ld_word);
      m_fifo.push_back(n);
    end
    if (pre == 0) begin
      m_starve = 0;
      m_stall  = 1'b0;
    end else if (popped) begin
      m_starve = 0;
    end else begin
      m_starve++;
      if (m_starve >= STARVE_MAX) m_stall = 1'b1;
    end
    e.addr  = m_addr;
    e.data  = m_data;
    e.stall = m_stall;
    e.count = m_fifo.size();
    exp_q.push_back(e);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_offset = '0; ld_word = '0;
  endtask

  task automatic rand_load();
    ld_rd     = 5'($urandom_range(1, 31));
    ld_funct3 = 3'($urandom);
    ld_offset = 2'($urandom);
    ld_word   = $urandom;
  endtask

  // Asynchronous reset asserted mid-cycle, then released on a negedge.
  task automatic reset_mid();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_we_immediate", 32'(we), 32'd0);
    chk("rst_count_immediate", 32'(ld_count), 32'd0);
    chk("rst_ready_low", 32'(ld_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_ready_held_low", 32'(ld_ready), 32'd0);
    chk("rst_addr", 32'(wa), 32'd0);
    chk("rst_data", wd, 32'd0);
    chk("rst_stall", 32'(alu_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready_release", 32'(ld_ready), 32'd1);
  endtask

  // Monitor: one expectation per non-reset edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(we), 32'd0);
        continue;
      end
      e = exp_q.pop_front();
      chk("write_en", 32'(we), 32'(e.en));
      chk("write_addr", 32'(wa), 32'(e.addr));
      chk("write_data", wd, e.data);
      chk("alu_stall", 32'(alu_stall), 32'(e.stall));
      chk("ld_count", 32'(ld_count), 32'(e.count));
      chk("ld_ready", 32'(ld_ready), 32'(e.count < DEPTH));
      chk("no_x0_write", 32'(we && wa == 5'd0), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  typedef struct {
    bit [2:0]  f3;
    bit [1:0]  off;
    bit [31:0] val;
  } ext_vec_t;

  initial begin
    ext_vec_t tbl[6];
    int       acc;
    int       guard;
    tbl[0] = '{3'b000, 2'd1, 32'hFFFF_FFF2};
    tbl[1] = '{3'b100, 2'd1, 32'h0000_00F2};
    tbl[2] = '{3'b001, 2'd2, 32'hFFFF_8001};
    tbl[3] = '{3'b101, 2'd0, 32'h0000_F2A4};
    tbl[4] = '{3'b010, 2'd0, 32'h8001_F2A4};
    tbl[5] = '{3'b011, 2'd0, 32'h8001_F2A4};

    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_addr", 32'(wa), 32'd0);
    chk("reset_data", wd, 32'd0);
    chk("reset_stall", 32'(alu_stall), 32'd0);
    chk("reset_count", 32'(ld_count), 32'd0);
    chk("reset_ready", 32'(ld_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(ld_ready), 32'd1);
    @(negedge clk);

    // Reset with three loads buffered behind a busy ALU.
    alu_valid = 1'b1; alu_rd = 5'd1;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; rand_load(); alu_data = $urandom;
      step();
    end
    idle_inputs();
    chk("buffered_before_reset", 32'(ld_count), 32'd3);
    reset_mid();

    // Extension table: load accepted at edge N, written at edge N+1.
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = tbl[i].f3; ld_offset = tbl[i].off;
      ld_word = 32'h8001_F2A4;
      step();
      ld_valid = 1'b0;
      step();
      chk("ext_table", wd, tbl[i].val);
    end
    for (int f = 0; f < 8; f++) begin
      for (int o = 0; o < 4; o++) begin
        ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'(f); ld_offset = 2'(o);
        ld_word = 32'h8001_F2A4;
        step();
        ld_valid = 1'b0;
        step();
      end
    end

    // Priority: ALU first, buffered load next edge.
    ld_valid = 1'b1; ld_rd = 5'd5; ld_funct3 = 3'b010; ld_word = 32'hCAFE_0005;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11;
    step();
    chk("prio_alu_addr", 32'(wa), 32'd7);
    chk("prio_alu_data", wd, 32'h11);
    idle_inputs();
    step();
    chk("prio_load_addr", 32'(wa), 32'd5);
    chk("prio_load_data", wd, 32'hCAFE_0005);

    // Zero destination: x0 ALU frees the slot, x0 load is swallowed.
    ld_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010; ld_word = 32'h0000_0909;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    step();
    alu_rd = 5'd0; alu_data = 32'hDEAD; ld_rd = 5'd0; ld_word = 32'hBAD0;
    chk("zero_rd_ready", 32'(ld_ready), 32'd1);
    step();
    chk("zero_alu_pops_addr", 32'(wa), 32'd9);
    chk("zero_ld_count", 32'(ld_count), 32'd0);
    idle_inputs();
    step();

    // Fill the FIFO behind continuous ALU traffic, then starve until the stall drains it.
    alu_valid = 1'b1; alu_rd = 5'd1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1; rand_load(); alu_data = $urandom;
      step();
    end
    ld_valid = 1'b0;
    chk("full_count", 32'(ld_count), 32'(DEPTH));
    chk("full_ready", 32'(ld_ready), 32'd0);
    guard = 0;
    while (!alu_stall && guard < 20) begin
      alu_data = $urandom;
      step();
      guard++;
    end
    chk("stall_reached", 32'(alu_stall), 32'd1);
    acc = 0;
    guard = 0;
    while (acc < 10 && guard < 80) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      rand_load(); alu_data = $urandom;
      if (ld_valid && ld_ready) acc++;
      step();
      guard++;
    end
    chk("pump_accepted", 32'(acc), 32'd10);
    ld_valid = 1'b0;
    repeat (20) begin
      alu_data = $urandom;
      step();
    end
    chk("stall_cleared", 32'(alu_stall), 32'd0);

    // Randomized traffic with one mid-run asynchronous reset.
    for (int n = 0; n < 800; n++) begin
      alu_valid = ($urandom_range(0, 3) != 0);
      if (alu_stall && $urandom_range(0, 7) != 0) alu_valid = 1'b0;
      alu_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_data = $urandom;
      ld_valid = $urandom_range(0, 1) == 1;
      rand_load();
      if ($urandom_range(0, 9) == 0) ld_rd = 5'd0;
      step();
      if (n == 400) begin
        idle_inputs();
        reset_mid();
      end
    end
    idle_inputs();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side producer for the integer register file: drives its single write port (WriteData, WriteAddress, RegWriteEn).
- Merges two sources:
  - the ALU result stream, one per cycle, with no backpressure;
  - late load responses from the data-memory path, with valid/ready handshake.
- Load responses are sign/zero-extended per funct3 and buffered in a small FIFO.
- Sits between the execute/memory stages and the register file.

Parameters:
- DEPTH, 4, load FIFO entries; power of 2, at least 2.
- STARVE_MAX, 8, consecutive blocked cycles before ALU is stalled to drain the FIFO.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- AluValid  in  1  ALU result present this cycle.
- AluRd  in  5  ALU destination register.
- AluData  in  32  ALU result.
- AluStall  out  1  registered; upstream must hold AluValid low while high.
- LdValid  in  1  load response valid.
- LdReady  out  1  FIFO can accept; equals !full, and is 0 while rst is high.
- LdRd  in  5  load destination register.
- LdFunct3  in  3  load type.
- LdOffset  in  2  byte address [1:0].
- LdWord  in  32  aligned memory word.
- LdCount  out  clog2(DEPTH)+1  FIFO occupancy.
- WriteData  out  32  register-file write data, registered.
- WriteAddress  out  5  register-file write address, registered.
- RegWriteEn  out  1  register-file write enable, registered.

Behaviour:
- Reset (async):
  - WriteData=0, WriteAddress=0, RegWriteEn=0, AluStall=0.
  - FIFO pointers, LdCount and starve counter cleared.
  - Reset mid-operation discards all buffered loads.
- Write-port timing:
  - Outputs change only on posedge clk.
  - The register file samples them on the following negedge, so one write occurs per cycle at most.
- Load push:
  - Occurs on posedge when LdValid && LdReady.
  - LdReady derives from the registered count only: no push when full, even if a pop happens in the same cycle.
  - Extension is computed before storing.
- Extension, with byte select LdOffset and halfword select LdOffset[1]:
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half.
  - 010 lw: whole word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - Other codes: treated as lw.
- Load with LdRd=0: handshake completes, nothing stored, LdCount unchanged.
- Per-posedge selection, in priority order:
  1. AluStall=0 and AluValid and AluRd!=0: RegWriteEn=1, WriteAddress=AluRd, WriteData=AluData.
  2. Else if FIFO non-empty: pop head; RegWriteEn=1 with the head's rd/data.
  3. Else RegWriteEn=0; WriteAddress/WriteData hold their previous values.
- Zero destination:
  - AluValid with AluRd=0 produces no write; that cycle is free for a FIFO pop.
  - x0 is never written.
- Load latency:
  - No bypass; a load accepted at edge N appears on the write port at edge N+1 at the earliest.
  - ALU latency is one edge.
- Simultaneous push and pop: both occur; LdCount is unchanged.
- Starvation guard:
  - Starve counter increments on each edge where FIFO is non-empty and no pop occurs; it clears on any pop or when FIFO is empty.
  - AluStall is set at the edge where the counter reaches STARVE_MAX, and clears on the edge after the FIFO becomes empty.
  - AluValid asserted while AluStall=1 is a protocol violation: the ALU input is dropped and the FIFO pops.
- Pointer wrap: read and write pointers wrap modulo DEPTH. LdCount ranges 0..DEPTH.

Test Plan:
1. Reset with loads buffered:
   - Stimulus: push 3 loads, assert rst asynchronously mid-cycle.
   - Response: RegWriteEn=0 and LdCount=0 immediately; LdReady=0 while rst high, 1 after release.
2. Load extension:
   - Stimulus: LdWord=0x8001_F2A4 at each offset for lb, lh, lw, lbu, lhu.
   - Response:
     - lb off1 -> 0xFFFF_FFF2; lbu off1 -> 0x0000_00F2.
     - lh off2 -> 0xFFFF_8001; lhu off0 -> 0x0000_F2A4.
     - lw -> 0x8001_F2A4; funct3=011 -> 0x8001_F2A4.
3. Priority:
   - Stimulus: one load to x5 buffered; AluValid with AluRd=7, AluData=0x11 on the same edge.
   - Response: x7 written first; x5 written on the next edge.
4. Zero destination:
   - Stimulus: AluValid with AluRd=0 while one load is buffered; also a load with LdRd=0.
   - Response: the buffered load pops that edge; LdRd=0 load completes the handshake with LdCount unchanged; no write to address 0 ever.
5. Full FIFO:
   - Stimulus: DEPTH loads pushed with continuous AluValid to x1.
   - Response: LdCount=4, LdReady=0.
6. Starvation and wrap:
   - Stimulus: continue from scenario 5 with continuous AluValid to x1, then pump 10 more loads with wrap-around.
   - Response: AluStall=1 after 8 blocked edges; FIFO drains all 4 loads in order; AluStall clears after empty; pointer wrap preserves order.
